machine_result_capture: RTL and testbench
=========================================

MACHINE_RESULT_CAPTURE -- requirements
Module: machine_result_capture

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; SHALL be a power of two, 2..64.
REQ-002 Parameter TARGET, default 64, captured-entry count at which done asserts; SHALL be 1..65535.
REQ-003 Port system1000  in  1  the single clock; all logic SHALL be rising-edge on it.
REQ-004 Port system1000_rstn  in  1  reset, synchronous and active-low.
REQ-005 Port result  in  13  machine result word, sampled every cycle.
REQ-006 Port cap_en  in  1  capture enable; no capture while low.
REQ-007 Port out_valid  out  1  FIFO head is valid.
REQ-008 Port out_ready  in  1  consumer accepts head when out_valid and out_ready are both high.
REQ-009 Port out_data  out  13  FIFO head result value.
REQ-010 Port overflow  out  1  sticky: a capture was dropped because the FIFO was full.
REQ-011 Port done  out  1  sticky: captured count reached TARGET.
REQ-012 Port level  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Capture event SHALL occur when cap_en=1 and (first_seen=0 or result differs from last_captured).
REQ-014 On a capture event, last_captured SHALL load result and first_seen SHALL set, including when the push is dropped.
REQ-015 A capture event SHALL push result into the FIFO unless FIFO is full and no pop occurs in the same cycle.
REQ-016 A pop SHALL occur when out_valid=1 and out_ready=1, advancing the head on the next edge.
REQ-017 When push and pop coincide with FIFO full, both SHALL complete and level SHALL stay at DEPTH.
REQ-018 When push and pop coincide with FIFO empty, out_valid SHALL be low that cycle and the pushed word SHALL appear the next cycle; there SHALL be no combinational bypass.
REQ-019 Latency: a value sampled at edge N into an empty FIFO SHALL show out_valid=1 with out_data equal to that value after edge N.
REQ-020 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 A dropped push SHALL set overflow; overflow SHALL clear only on reset.
REQ-022 The captured counter, 16 bits, SHALL increment on every accepted push and saturate at TARGET.
REQ-023 done SHALL assert the cycle after the counter reaches TARGET and SHALL remain asserted; captures SHALL continue afterwards.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL use an extra pointer bit.

Reset
REQ-025 While system1000_rstn=0 at an edge, the block SHALL clear out_valid, overflow, done, level, pointers, counter, first_seen and last_captured to 0, and out_data SHALL read 0.
REQ-026 Reset mid-stream SHALL discard FIFO contents; the first enabled sample after release SHALL be captured regardless of value.

Configuration
REQ-027 With macro MACHINE_CAPTURE_TIMESTAMP_EN defined, a 16-bit free-running cycle counter, reset to 0 and wrapping, SHALL be stored with each entry and presented on an extra output port out_ts (16 bits) aligned with out_data.
REQ-028 Without MACHINE_CAPTURE_TIMESTAMP_EN, out_ts and the timestamp counter SHALL be absent, and FIFO width SHALL be 13.

Structure
REQ-029 Package machine_capture_pkg SHALL hold RESULT_W=13, TS_W=16, CNT_W=16 and the FIFO entry struct typedef; the struct gains a ts field under the macro.
REQ-030 Sub-module machine_capture_fifo, a parameterised synchronous FIFO with registered output and level, SHALL hold the storage; the change detector and counters SHALL live in the top module.

Verification
REQ-031 Reset, then cap_en=1 with result constant 0x0005 for 10 cycles, out_ready=1 -> exactly one entry, 0x0005; level returns to 0.
REQ-032 out_ready=0, DEPTH=8, feed 10 distinct values 1..10 -> level=8, overflow=1 from the 9th capture, entries 1..8 drain in order when out_ready=1.
REQ-033 FIFO full, push value 0x1FFF and pop in the same cycle -> level stays 8 and 0x1FFF is last out; overflow remains 0 if previously 0.
REQ-034 TARGET=4, values 1,2,3,4 captured -> done=1 one cycle after the 4th push; 5th value still enqueued.
REQ-035 Reset asserted with 3 entries queued, then released with result=0x0005, equal to last pre-reset capture -> out_valid=0 during reset, then 0x0005 captured once.
REQ-036 With MACHINE_CAPTURE_TIMESTAMP_EN, reset, captures at cycles 2 and 7 after release -> out_ts values 2 and 7.

Source files
------------

// File: rtl/machine_capture_pkg.sv
// Shared widths and the FIFO entry layout for the machine result capture block.
// Ports: none (package only).
// Optional feature macro: MACHINE_CAPTURE_TIMESTAMP_EN adds a ts field to entry_t.
package machine_capture_pkg;

  localparam int RESULT_W = 13;
  localparam int TS_W     = 16;
  localparam int CNT_W    = 16;

  // One FIFO slot. ts sits above result so the result always occupies the low bits.
  typedef struct packed {
`ifdef MACHINE_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0]     ts;
`endif
    logic [RESULT_W-1:0] result;
  } entry_t;

endpackage

// File: rtl/machine_capture_fifo.sv
// Synchronous FIFO, DEPTH entries of W bits; head and level come straight from flops.
// Ports: clk/rstn (sync active-low), wr_en/wr_data/wr_ok write side, rd_en pop request,
//        out_valid/out_data head, level occupancy. A write is refused only when full with no pop.
module machine_capture_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 13
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  output logic                   wr_ok,
  input  logic                   rd_en,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         empty;
  logic         pop;

  // Extra MSB on each pointer separates full (MSBs differ) from empty (all equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop   = rd_en && !empty;
  // A pop frees the slot at the same edge, so a write into a full FIFO still lands.
  assign wr_ok = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until a pointer moves past it.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign out_valid = !empty;
  // Gate the head so stale storage never leaks out while empty (reads 0 after reset).
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign level     = wr_ptr - rd_ptr;

endmodule

// File: rtl/machine_result_capture.sv
// Captures changes of a 13-bit machine result into a FIFO, with sticky overflow and done flags.
// Ports: system1000 clock, system1000_rstn sync active-low reset, result/cap_en in,
//        out_valid/out_ready/out_data/level FIFO head, overflow/done status.
// Macro MACHINE_CAPTURE_TIMESTAMP_EN adds a free-running cycle stamp per entry on out_ts.
module machine_result_capture
  import machine_capture_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TARGET = 64
) (
  input  logic                   system1000,
  input  logic                   system1000_rstn,
  input  logic [RESULT_W-1:0]    result,
  input  logic                   cap_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RESULT_W-1:0]    out_data,
  output logic                   overflow,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level
`ifdef MACHINE_CAPTURE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]        out_ts
`endif
);

  logic                first_seen;
  logic [RESULT_W-1:0] last_captured;
  logic [CNT_W-1:0]    captured;
  logic                capture;
  logic                push_ok;
  entry_t              wr_entry;
  entry_t              head;

`ifdef MACHINE_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0]     ts_cnt;

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) ts_cnt <= '0;
    else                  ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  // The first enabled sample after reset is always taken; afterwards only changes are.
  assign capture = cap_en && (!first_seen || (result != last_captured));

  always_comb begin
    wr_entry        = '0;
    wr_entry.result = result;
`ifdef MACHINE_CAPTURE_TIMESTAMP_EN
    wr_entry.ts     = ts_cnt;
`endif
  end

  machine_capture_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk       (system1000),
    .rstn      (system1000_rstn),
    .wr_en     (capture),
    .wr_data   (wr_entry),
    .wr_ok     (push_ok),
    .rd_en     (out_ready),
    .out_valid (out_valid),
    .out_data  (head),
    .level     (level)
  );

  assign out_data = head.result;
`ifdef MACHINE_CAPTURE_TIMESTAMP_EN
  assign out_ts   = head.ts;
`endif

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      first_seen    <= 1'b0;
      last_captured <= '0;
      captured      <= '0;
      overflow      <= 1'b0;
      done          <= 1'b0;
    end else begin
      // The change detector tracks the sample even when the FIFO refuses it,
      // so a dropped value is not retried on the following cycles.
      if (capture) begin
        last_captured <= result;
        first_seen    <= 1'b1;
        if (!push_ok) overflow <= 1'b1;
      end
      if (push_ok && (captured != CNT_W'(TARGET))) captured <= captured + 1'b1;
      // Registered off the counter, so done rises one cycle after the target push.
      if (captured == CNT_W'(TARGET)) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_machine_result_capture.sv
module tb_machine_result_capture;
  import machine_capture_pkg::*;

  logic                clk = 1'b0;
  logic                rstn;
  logic [RESULT_W-1:0] result;
  logic                cap_en;
  logic                out_valid;
  logic                out_ready;
  logic [RESULT_W-1:0] out_data;
  logic                overflow;
  logic                done;
  logic [3:0]          level;
`ifdef MACHINE_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0]     out_ts;
`endif

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  machine_result_capture #(
    .DEPTH  (8),
    .TARGET (4)
  ) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .result          (result),
    .cap_en          (cap_en),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .overflow        (overflow),
    .done            (done),
    .level           (level)
`ifdef MACHINE_CAPTURE_TIMESTAMP_EN
    ,
    .out_ts          (out_ts)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns so inputs and samples stay clear of the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    cap_en    = 1'b0;
    out_ready = 1'b0;
    result    = '0;
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    int seen;
    logic [31:0] exp;

    // Reset state
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);

    // Constant input: one capture, visible right after the capturing edge
    cap_en = 1'b1; result = 13'h0005; out_ready = 1'b1;
    step();
    check("const_valid", 32'(out_valid), 32'd1);
    check("const_data", 32'(out_data), 32'h5);
    check("const_level", 32'(level), 32'd1);
    seen = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("const_entries", 32'(seen), 32'd1);
    check("const_level_end", 32'(level), 32'd0);

    // Fill past full with out_ready low: overflow from the 9th, done after 4th push
    do_reset();
    cap_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      result = 13'(i);
      step();
      check("fill_level", 32'(level), (i < 8) ? 32'(i) : 32'd8);
      if (i == 4) check("done_at4", 32'(done), 32'd0);
      if (i == 5) check("done_at5", 32'(done), 32'd1);
      if (i == 8) check("ovf_at8", 32'(overflow), 32'd0);
      if (i == 9) check("ovf_at9", 32'(overflow), 32'd1);
    end
    cap_en = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data", 32'(out_data), 32'(k));
      step();
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("done_sticky", 32'(done), 32'd1);

    // Push and pop together on a full FIFO
    do_reset();
    cap_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      result = 13'(i);
      step();
    end
    check("full_level", 32'(level), 32'd8);
    check("full_ovf", 32'(overflow), 32'd0);
    result = 13'h1FFF; out_ready = 1'b1;
    step();
    check("pp_level", 32'(level), 32'd8);
    check("pp_ovf", 32'(overflow), 32'd0);
    cap_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = (k < 7) ? 32'(k + 2) : 32'h1FFF;
      check("pp_data", 32'(out_data), exp);
      step();
    end
    check("pp_empty", 32'(out_valid), 32'd0);

    // Mid-stream reset, released with the same value as the last capture
    do_reset();
    cap_en = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      result = 13'(i);
      step();
    end
    check("pre_level", 32'(level), 32'd3);
    rstn = 1'b0;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    rstn = 1'b1;
    step();
    check("post_valid", 32'(out_valid), 32'd1);
    check("post_data", 32'(out_data), 32'h5);
    step();
    check("post_once", 32'(level), 32'd1);
    check("hold_data", 32'(out_data), 32'h5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
